// File: rtl/player_motion_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | player_motion_pkg                                                    |
// | Air-state encoding, default tuning constants and sign-extend helper. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package player_motion_pkg;

  typedef enum logic [1:0] {
    AIR_GROUNDED = 2'd0,
    AIR_RISING   = 2'd1,
    AIR_FALLING  = 2'd2
  } air_state_t;

  localparam int DEF_X_W          = 10;
  localparam int DEF_Y_W          = 10;
  localparam int DEF_V_W          = 8;
  localparam int DEF_SCREEN_W     = 640;
  localparam int DEF_PLAYER_W     = 16;
  localparam int DEF_PLAYER_H     = 16;
  localparam int DEF_H_SPEED      = 3;
  localparam int DEF_GRAVITY      = 1;
  localparam int DEF_JUMP_VEL     = -11;
  localparam int DEF_JUMP_CUT_VEL = -4;
  localparam int DEF_MAX_FALL_VEL = 8;
  localparam int DEF_COYOTE_TICKS = 4;
  localparam int DEF_JUMP_BUF     = 4;
  localparam int DEF_START_X      = 20;
  localparam int DEF_START_Y      = 344;

  // Sign-extends the low w bits of v to 32 bits; callers truncate to Y_W.
  function automatic logic [31:0] sext(input logic [31:0] v, input int unsigned w);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << w;
    return v[5'(w - 1)] ? (v | m) : (v & ~m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/player_motion_core_countdown.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tick_countdown                                                       |
// | Loadable down-counter that saturates at zero; load wins over dec.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tick_countdown #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/player_motion_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | player_motion_core                                                   |
// | Per-tick player physics: walk, jump, gravity, coyote/buffer, clamps. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module player_motion_core
  import player_motion_pkg::*;
#(
  parameter int X_W            = DEF_X_W,
  parameter int Y_W            = DEF_Y_W,
  parameter int V_W            = DEF_V_W,
  parameter int SCREEN_W       = DEF_SCREEN_W,
  parameter int PLAYER_W       = DEF_PLAYER_W,
  parameter int PLAYER_H       = DEF_PLAYER_H,
  parameter int H_SPEED        = DEF_H_SPEED,
  parameter int GRAVITY        = DEF_GRAVITY,
  parameter int JUMP_VEL       = DEF_JUMP_VEL,
  parameter int JUMP_CUT_VEL   = DEF_JUMP_CUT_VEL,
  parameter int MAX_FALL_VEL   = DEF_MAX_FALL_VEL,
  parameter int COYOTE_TICKS   = DEF_COYOTE_TICKS,
  parameter int JUMP_BUF_TICKS = DEF_JUMP_BUF,
  parameter int START_X        = DEF_START_X,
  parameter int START_Y        = DEF_START_Y
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           game_tick,
  input  logic           move_left,
  input  logic           move_right,
  input  logic           jump,
  input  logic           on_ground,
  input  logic [Y_W-1:0] support_y,
  input  logic           hit_ceiling,
  input  logic           hit_left_wall,
  input  logic           hit_right_wall,
  input  logic           freeze,
  input  logic           respawn,
  output logic [X_W-1:0] player_x,
  output logic [Y_W-1:0] player_y,
  output logic [V_W-1:0] vy,
  output logic [1:0]     air_state,
  output logic           jump_landed_pulse
);

  localparam int CW_COY = (COYOTE_TICKS > 1) ? $clog2(COYOTE_TICKS + 1) : 1;
  localparam int CW_BUF = (JUMP_BUF_TICKS > 1) ? $clog2(JUMP_BUF_TICKS + 1) : 1;

  localparam logic [X_W-1:0]        C_XMAX    = X_W'(SCREEN_W - PLAYER_W);
  localparam logic [X_W-1:0]        C_HSPD    = X_W'(H_SPEED);
  localparam logic [X_W-1:0]        C_START_X = X_W'(START_X);
  localparam logic [Y_W-1:0]        C_START_Y = Y_W'(START_Y);
  localparam logic [Y_W-1:0]        C_PH      = Y_W'(PLAYER_H);
  localparam logic [Y_W-1:0]        C_DY_JUMP = Y_W'(JUMP_VEL);
  localparam logic [V_W-1:0]        C_JUMP_V  = V_W'(JUMP_VEL);
  localparam logic signed [V_W:0]   C_CUT     = (V_W+1)'(JUMP_CUT_VEL);
  localparam logic signed [V_W:0]   C_GRAV    = (V_W+1)'(GRAVITY);
  localparam logic signed [V_W:0]   C_MAXF    = (V_W+1)'(MAX_FALL_VEL);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [V_W-1:0] vy_q, vy_d;
  air_state_t     state_q, state_d;
  logic           jump_prev_q, jump_prev_d;
  logic           pulse_q, pulse_d;

  logic w_tick, w_press, w_launch, w_landing;
  logic w_coy_zero, w_buf_zero;
  logic w_coy_load, w_buf_load;
  logic [CW_COY-1:0] w_coy_val;
  logic [CW_BUF-1:0] w_buf_val;

  logic signed [V_W:0] w_vy_ext, w_vy_cut, w_vy_grav, w_vy_next;
  logic [Y_W-1:0]      w_dy;
  logic [X_W:0]        w_x_sum;
  logic [X_W-1:0]      w_x_left, w_x_right;

  assign w_tick    = game_tick & ~freeze;
  assign w_press   = jump & ~jump_prev_q;
  assign w_launch  = (w_press | ~w_buf_zero) & (on_ground | ~w_coy_zero)
                   & (state_q != AIR_RISING);
  assign w_landing = on_ground & ~w_launch & ~vy_q[V_W-1];

  // Respawn reuses the load path with a zero value to clear both counters.
  assign w_coy_load = respawn | (w_tick & (w_launch | (state_q == AIR_GROUNDED)));
  assign w_coy_val  = (respawn | w_launch) ? '0 : CW_COY'(COYOTE_TICKS);
  assign w_buf_load = respawn | (w_tick & (w_launch | w_press));
  assign w_buf_val  = (respawn | w_launch) ? '0 : CW_BUF'(JUMP_BUF_TICKS);

  tick_countdown #(.W(CW_COY)) u_coy (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_coy_load),
    .load_val_i (w_coy_val),
    .dec_i      (w_tick),
    .zero_o     (w_coy_zero)
  );

  tick_countdown #(.W(CW_BUF)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_buf_load),
    .load_val_i (w_buf_val),
    .dec_i      (w_tick),
    .zero_o     (w_buf_zero)
  );

  // One extra bit keeps the fall clamp correct when vy+GRAVITY overflows V_W.
  always_comb begin
    w_vy_ext = {vy_q[V_W-1], vy_q};
    w_vy_cut = w_vy_ext;
    if ((state_q == AIR_RISING) && !jump && (w_vy_ext < C_CUT)) begin
      w_vy_cut = C_CUT;
    end
    w_vy_grav = w_vy_cut + C_GRAV;
    w_vy_next = (w_vy_grav > C_MAXF) ? C_MAXF : w_vy_grav;
  end

  assign w_dy      = Y_W'(sext(32'(w_vy_next[V_W-1:0]), V_W));
  assign w_x_sum   = {1'b0, x_q} + {1'b0, C_HSPD};
  assign w_x_left  = (x_q < C_HSPD) ? '0 : (x_q - C_HSPD);
  assign w_x_right = (w_x_sum > {1'b0, C_XMAX}) ? C_XMAX : w_x_sum[X_W-1:0];

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    vy_d        = vy_q;
    state_d     = state_q;
    jump_prev_d = jump_prev_q;
    pulse_d     = 1'b0;
    if (respawn) begin
      x_d         = C_START_X;
      y_d         = C_START_Y;
      vy_d        = '0;
      state_d     = AIR_GROUNDED;
      jump_prev_d = 1'b0;
    end else if (w_tick) begin
      jump_prev_d = jump;
      if (move_left && !move_right && !hit_left_wall) begin
        x_d = w_x_left;
      end else if (move_right && !move_left && !hit_right_wall) begin
        x_d = w_x_right;
      end
      if (w_launch) begin
        vy_d    = C_JUMP_V;
        y_d     = y_q + C_DY_JUMP;
        state_d = AIR_RISING;
      end else if (w_landing) begin
        y_d     = support_y - C_PH;
        vy_d    = '0;
        state_d = AIR_GROUNDED;
        pulse_d = (state_q != AIR_GROUNDED);
      end else if (hit_ceiling && w_vy_next[V_W]) begin
        vy_d    = '0;
        state_d = AIR_FALLING;
      end else begin
        vy_d    = w_vy_next[V_W-1:0];
        y_d     = y_q + w_dy;
        state_d = ((state_q == AIR_RISING) && w_vy_next[V_W]) ? AIR_RISING : AIR_FALLING;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q         <= C_START_X;
      y_q         <= C_START_Y;
      vy_q        <= '0;
      state_q     <= AIR_GROUNDED;
      jump_prev_q <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      vy_q        <= vy_d;
      state_q     <= state_d;
      jump_prev_q <= jump_prev_d;
      pulse_q     <= pulse_d;
    end
  end

  assign player_x          = x_q;
  assign player_y          = y_q;
  assign vy                = vy_q;
  assign air_state         = state_q;
  assign jump_landed_pulse = pulse_q;

endmodule
`default_nettype wire

// File: doc/player_motion_core.md
Name: player_motion_core

Overview:
Parametrised successor to the current player physics block. Integrates horizontal motion and vertical velocity/gravity once per game_tick, and adds coyote time, jump buffering, variable jump height (early release cuts the rise), saturating screen clamps, respawn and an explicit air-state output. It sits between the input debouncer/collision detector and the renderer/sound/score logic, which consume position, air_state and the landing pulse.

Parameters:
X_W, 10, player_x width
Y_W, 10, player_y/support_y width
V_W, 8, signed vertical velocity width
SCREEN_W, 640, playfield width in pixels
PLAYER_W, 16, sprite width
PLAYER_H, 16, sprite height
H_SPEED, 3, pixels per tick horizontally
GRAVITY, 1, velocity increment per airborne tick
JUMP_VEL, -11, launch velocity (signed)
JUMP_CUT_VEL, -4, velocity ceiling applied on early jump release
MAX_FALL_VEL, 8, downward velocity clamp
COYOTE_TICKS, 4, ticks a jump remains legal after walking off a ledge
JUMP_BUF_TICKS, 4, ticks a jump press is remembered before landing
START_X, 20, reset/respawn x
START_Y, 344, reset/respawn y

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
game_tick  in  1  one-clk strobe; all motion updates occur on it
move_left  in  1  level
move_right  in  1  level
jump  in  1  level (held = button down)
on_ground  in  1  collision: feet on support
support_y  in  Y_W  top edge of supporting surface
hit_ceiling  in  1  collision above
hit_left_wall  in  1  collision left
hit_right_wall  in  1  collision right
freeze  in  1  hold all state on ticks
respawn  in  1  synchronous one-clk request
player_x  out  X_W  registered
player_y  out  Y_W  registered
vy  out  V_W  signed velocity, registered
air_state  out  2  0=GROUNDED 1=RISING 2=FALLING
jump_landed_pulse  out  1  one-clk landing strobe

Behaviour:
- Reset: x=START_X, y=START_Y, vy=0, air_state=GROUNDED, counters=0, jump_prev=0, pulse=0.
- respawn (any clk, priority over freeze and tick): same values as reset.
- jump_landed_pulse is high for exactly the clk cycle after the landing tick; 0 otherwise.
- Outputs change only in the cycle after a game_tick with freeze=0. Freeze holds everything, including counters and jump_prev.
- Horizontal, exclusive L/R only: left x'=max(x-H_SPEED,0) unless hit_left_wall; right x'=min(x+H_SPEED, SCREEN_W-PLAYER_W) unless hit_right_wall. Both or neither pressed: hold.
- Edge detect: press = jump & ~jump_prev; jump_prev updated each tick.
- Buffer: press loads buf=JUMP_BUF_TICKS; otherwise buf decrements to 0 each tick.
- Coyote: while GROUNDED, coy=COYOTE_TICKS; airborne, decrements to 0. A launch zeroes coy and buf.
- Launch condition: (press|buf>0) & (on_ground|coy>0) & air_state!=RISING. Result: vy=JUMP_VEL, y+=sext(JUMP_VEL), state RISING. Launch beats landing.
- Airborne, no launch: if RISING & ~jump & vy<JUMP_CUT_VEL then vy=JUMP_CUT_VEL. Then vy'=min(vy+GRAVITY, MAX_FALL_VEL) and y'=y+sext(vy').
  - hit_ceiling & vy'<0: vy'=0, y held, state FALLING.
  - Otherwise RISING→FALLING when vy'≥0.
- Landing: on_ground & not launching & vy≥0 → y=support_y-PLAYER_H, vy=0, GROUNDED. Pulse fires if the previous state was not GROUNDED.
- Walk-off: GROUNDED & ~on_ground → FALLING with gravity applied the same tick.
- Arithmetic: velocity is sign-extended to Y_W. Signed compares use V_W+1 bits to avoid clamp overflow.

Decomposition:
- Package player_motion_pkg: air_state enum (GROUNDED/RISING/FALLING), default constants above, and a sext-to-Y_W helper function.
- Sub-module tick_countdown: loadable saturating down-counter with load, dec and zero flag. Instantiated twice, for coyote and buffer.

Test Plan:
- Reset, then 10 ticks with no input → x=20, y=344, vy=0, GROUNDED; rst mid-jump → immediate return to these values.
- Press jump on ground, hold 30 ticks → first tick y=333, vy=-11. Apex after 11 ticks, FALLING, lands back on y=344 with one 1-clk pulse.
- Press, release after 2 ticks → vy clamps to -4 on release tick, lower apex than the held case.
- Walk off ledge, press jump on 3rd airborne tick → launch happens (coyote). Press on 5th tick → no launch.
- Press jump 3 ticks before on_ground asserts → launch on the landing tick, no GROUNDED dwell, no pulse.
- x=2 holding left → x=0 and stays 0. x=622 holding right → stays 624 max. freeze during a fall → all outputs constant. Fall speed never exceeds vy=8.
